// File: rtl/debugger_mailbox_controller.sv
// Debugger mailbox controller: on a PS doorbell it validates the BRAM mailbox, hands the
// request type to the processor, writes the response block back and pulses the PS interrupt.
module debugger_mailbox_controller #(
    parameter int                    ADDR_WIDTH       = 13,
    parameter int                    DATA_WIDTH       = 32,
    parameter logic [DATA_WIDTH-1:0] INDICATOR        = 32'h4859_5045,
    parameter logic [15:0]           RESP_BASE        = 16'h0100,
    parameter int                    TIMEOUT_CYCLES   = 1024,
    parameter int                    INT_PULSE_CYCLES = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  io_en,
    input  logic                  io_plInSignal,
    output logic                  io_psOutInterrupt,
    output logic [ADDR_WIDTH-1:0] io_rdWrAddr,
    output logic                  io_wrEna,
    output logic [DATA_WIDTH-1:0] io_wrData,
    input  logic [DATA_WIDTH-1:0] io_rdData,
    output logic                  io_reqValid,
    output logic [DATA_WIDTH-1:0] io_reqType,
    input  logic                  io_respValid,
    input  logic [DATA_WIDTH-1:0] io_respType,
    output logic                  io_busy,
    output logic [7:0]            io_errCount
);

    localparam int MAX_WAIT = (TIMEOUT_CYCLES > INT_PULSE_CYCLES) ? TIMEOUT_CYCLES : INT_PULSE_CYCLES;
    localparam int CNT_W    = $clog2(MAX_WAIT + 1);

    typedef enum logic [3:0] {
        IDLE,
        RD_IND,
        CHK_IND,
        LATCH_TYPE,
        WAIT_PROC,
        WR_CHK,
        WR_IND,
        WR_TYPE,
        INT
    } stateT;

    stateT                 state;
    stateT                 nextState;
    logic                  plPrev;
    logic                  doorbell;
    logic                  errInc;
    logic [CNT_W-1:0]      cycleCnt;
    logic [DATA_WIDTH-1:0] reqTypeReg;
    logic [DATA_WIDTH-1:0] respTypeReg;
    logic [DATA_WIDTH-1:0] nextReqType;
    logic [DATA_WIDTH-1:0] nextRespType;

    assign doorbell = io_plInSignal & ~plPrev;
    assign io_busy  = (state != IDLE);

    // The shared counter restarts on every state change, so it measures time spent in WAIT_PROC or INT
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            plPrev      <= 1'b0;
            cycleCnt    <= '0;
            reqTypeReg  <= '0;
            respTypeReg <= '0;
            io_errCount <= 8'd0;
        end else begin
            state       <= nextState;
            plPrev      <= io_plInSignal;
            reqTypeReg  <= nextReqType;
            respTypeReg <= nextRespType;
            if (nextState != state || state == IDLE) begin
                cycleCnt <= '0;
            end else begin
                cycleCnt <= cycleCnt + 1'b1;
            end
            if (errInc && io_errCount != 8'hFF) begin
                io_errCount <= io_errCount + 8'd1;
            end
        end
    end

    always_comb begin
        nextState         = state;
        nextReqType       = reqTypeReg;
        nextRespType      = respTypeReg;
        errInc            = 1'b0;
        io_rdWrAddr       = '0;
        io_wrEna          = 1'b0;
        io_wrData         = '0;
        io_reqValid       = 1'b0;
        io_reqType        = '0;
        io_psOutInterrupt = 1'b0;

        case (state)
            IDLE: begin
                if (io_en && doorbell) nextState = RD_IND;
            end
            RD_IND: begin
                io_rdWrAddr = ADDR_WIDTH'(1);
                nextState   = CHK_IND;
            end
            // io_rdData now holds word 1, requested in RD_IND
            CHK_IND: begin
                io_rdWrAddr = ADDR_WIDTH'(2);
                if (io_rdData == INDICATOR) begin
                    nextState = LATCH_TYPE;
                end else begin
                    errInc    = 1'b1;
                    nextState = IDLE;
                end
            end
            LATCH_TYPE: begin
                nextReqType = io_rdData;
                nextState   = WAIT_PROC;
            end
            WAIT_PROC: begin
                io_reqValid = 1'b1;
                io_reqType  = reqTypeReg;
                if (io_respValid) begin
                    nextRespType = io_respType;
                    nextState    = WR_CHK;
                end else if (cycleCnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    nextRespType = '1;
                    errInc       = 1'b1;
                    nextState    = WR_CHK;
                end
            end
            WR_CHK: begin
                io_wrEna    = 1'b1;
                io_rdWrAddr = ADDR_WIDTH'(RESP_BASE);
                io_wrData   = INDICATOR ^ respTypeReg;
                nextState   = WR_IND;
            end
            WR_IND: begin
                io_wrEna    = 1'b1;
                io_rdWrAddr = ADDR_WIDTH'(RESP_BASE + 16'd1);
                io_wrData   = INDICATOR;
                nextState   = WR_TYPE;
            end
            WR_TYPE: begin
                io_wrEna    = 1'b1;
                io_rdWrAddr = ADDR_WIDTH'(RESP_BASE + 16'd2);
                io_wrData   = respTypeReg;
                nextState   = INT;
            end
            INT: begin
                io_psOutInterrupt = 1'b1;
                if (cycleCnt == CNT_W'(INT_PULSE_CYCLES - 1)) nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase

        // Disabling aborts everything except an interrupt pulse already under way
        if (!io_en && state != INT) begin
            nextState    = IDLE;
            nextReqType  = reqTypeReg;
            nextRespType = respTypeReg;
            errInc       = 1'b0;
            io_wrEna     = 1'b0;
        end
    end

endmodule

// File: tb/tb_debugger_mailbox_controller.sv
// Self-checking bench for debugger_mailbox_controller: BRAM model, write scoreboard and
// one task per scenario.
module tb_debugger_mailbox_controller;

    localparam int          ADDR_WIDTH = 13;
    localparam int          DATA_WIDTH = 32;
    localparam logic [31:0] IND        = 32'h4859_5045;
    localparam logic [12:0] RBASE      = 13'h0100;

    typedef struct {
        logic [12:0] addr;
        logic [31:0] data;
    } wrExpT;

    logic        clock = 1'b0;
    logic        reset;
    logic        io_en;
    logic        io_plInSignal;
    logic        io_psOutInterrupt;
    logic [12:0] io_rdWrAddr;
    logic        io_wrEna;
    logic [31:0] io_wrData;
    logic [31:0] io_rdData;
    logic        io_reqValid;
    logic [31:0] io_reqType;
    logic        io_respValid;
    logic [31:0] io_respType;
    logic        io_busy;
    logic [7:0]  io_errCount;

    logic [31:0] mem [0:8191];
    wrExpT       expWrites[$];
    int          vectors     = 0;
    int          miscompares = 0;
    int          intCycles   = 0;
    int          reqRises    = 0;
    logic        prevReq     = 1'b0;
    int          expErr      = 0;

    debugger_mailbox_controller #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH)
    ) dut (
        .clock(clock),
        .reset(reset),
        .io_en(io_en),
        .io_plInSignal(io_plInSignal),
        .io_psOutInterrupt(io_psOutInterrupt),
        .io_rdWrAddr(io_rdWrAddr),
        .io_wrEna(io_wrEna),
        .io_wrData(io_wrData),
        .io_rdData(io_rdData),
        .io_reqValid(io_reqValid),
        .io_reqType(io_reqType),
        .io_respValid(io_respValid),
        .io_respType(io_respType),
        .io_busy(io_busy),
        .io_errCount(io_errCount)
    );

    always #5 clock = ~clock;

    // BRAM with one cycle of read latency
    always @(posedge clock) begin
        io_rdData <= mem[io_rdWrAddr];
        if (io_wrEna) mem[io_rdWrAddr] <= io_wrData;
    end

    // Write scoreboard plus interrupt and request-edge counters
    always @(negedge clock) begin
        if (io_wrEna === 1'b1) begin
            vectors++;
            if (expWrites.size() == 0) begin
                miscompares++;
                $display("[TB] FAIL unexpected_write: addr=%h data=%h, no write expected", io_rdWrAddr, io_wrData);
            end else begin
                wrExpT e;
                e = expWrites.pop_front();
                if (io_rdWrAddr !== e.addr || io_wrData !== e.data) begin
                    miscompares++;
                    $display("[TB] FAIL write: got addr=%h data=%h, want addr=%h data=%h",
                             io_rdWrAddr, io_wrData, e.addr, e.data);
                end
            end
        end
        if (io_psOutInterrupt === 1'b1) intCycles++;
        if (io_reqValid === 1'b1 && !prevReq) reqRises++;
        prevReq = (io_reqValid === 1'b1);
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Leaves the doorbell high at the start of cycle C
    task automatic ringDoorbell();
        io_plInSignal = 1'b0;
        step();
        io_plInSignal = 1'b1;
    endtask

    task automatic pushResponse(input logic [31:0] t);
        expWrites.push_back('{RBASE, IND ^ t});
        expWrites.push_back('{RBASE + 13'd1, IND});
        expWrites.push_back('{RBASE + 13'd2, t});
    endtask

    task automatic test_reset();
        reset = 1'b1; io_en = 1'b1; io_plInSignal = 1'b0; io_respValid = 1'b0; io_respType = '0;
        cycles(2);
        @(negedge clock);
        vectors++;
        if ({io_busy, io_wrEna, io_reqValid, io_psOutInterrupt} !== 4'b0 || io_rdWrAddr !== '0 ||
            io_wrData !== '0 || io_reqType !== '0 || io_errCount !== 8'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_outputs: busy=%b wrEna=%b req=%b int=%b addr=%h wrData=%h reqType=%h err=%0d, want all 0",
                     io_busy, io_wrEna, io_reqValid, io_psOutInterrupt, io_rdWrAddr, io_wrData, io_reqType, io_errCount);
        end
        reset = 1'b0;
        cycles(2);
        @(negedge clock);
        vectors++;
        if (io_busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_idle: busy=%b, want 0", io_busy);
        end
    endtask

    task automatic test_normal();
        int n;
        intCycles = 0; reqRises = 0;
        mem[1] = IND; mem[2] = 32'd7;
        pushResponse(32'd9);
        ringDoorbell();
        step();
        io_plInSignal = 1'b0;
        @(negedge clock);
        vectors++;
        if (io_busy !== 1'b1 || io_rdWrAddr !== 13'd1) begin
            miscompares++;
            $display("[TB] FAIL normal_rd_ind: busy=%b addr=%h, want 1/0001", io_busy, io_rdWrAddr);
        end
        step();
        @(negedge clock);
        vectors++;
        if (io_rdWrAddr !== 13'd2) begin
            miscompares++;
            $display("[TB] FAIL normal_chk_ind: addr=%h, want 0002", io_rdWrAddr);
        end
        step();
        @(negedge clock);
        vectors++;
        if (io_reqValid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL normal_early_req: reqValid=%b at C+3, want 0", io_reqValid);
        end
        step();
        @(negedge clock);
        vectors++;
        if (io_reqValid !== 1'b1 || io_reqType !== 32'd7) begin
            miscompares++;
            $display("[TB] FAIL normal_req: reqValid=%b reqType=%h at C+4, want 1/00000007", io_reqValid, io_reqType);
        end
        cycles(3);
        io_respValid = 1'b1; io_respType = 32'd9;
        step();
        io_respValid = 1'b0; io_respType = '0;
        @(negedge clock);
        vectors++;
        if (io_reqValid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL normal_req_drop: reqValid=%b after response, want 0", io_reqValid);
        end
        n = 0;
        while (io_busy === 1'b1 && n < 40) begin step(); @(negedge clock); n++; end
        vectors++;
        if (io_busy !== 1'b0 || intCycles != 4 || expWrites.size() != 0 || io_errCount !== 8'(expErr)) begin
            miscompares++;
            $display("[TB] FAIL normal_done: busy=%b intCycles=%0d pendingWrites=%0d err=%0d, want 0/4/0/%0d",
                     io_busy, intCycles, expWrites.size(), io_errCount, expErr);
        end
    endtask

    task automatic test_bad_indicator();
        intCycles = 0; reqRises = 0;
        mem[1] = 32'h0; mem[2] = 32'd7;
        ringDoorbell();
        step();
        io_plInSignal = 1'b0;
        step();
        step();
        expErr++;
        @(negedge clock);
        vectors++;
        if (io_busy !== 1'b0 || io_errCount !== 8'(expErr)) begin
            miscompares++;
            $display("[TB] FAIL bad_ind: busy=%b err=%0d at C+3, want 0/%0d", io_busy, io_errCount, expErr);
        end
        cycles(6);
        vectors++;
        if (reqRises != 0 || intCycles != 0) begin
            miscompares++;
            $display("[TB] FAIL bad_ind_quiet: reqRises=%0d intCycles=%0d, want 0/0", reqRises, intCycles);
        end
    endtask

    task automatic test_timeout();
        int n;
        intCycles = 0;
        mem[1] = IND; mem[2] = 32'd5;
        pushResponse(32'hFFFF_FFFF);
        ringDoorbell();
        step();
        io_plInSignal = 1'b0;
        cycles(3);
        n = 0;
        @(negedge clock);
        while (io_reqValid === 1'b1 && n < 2000) begin n++; step(); @(negedge clock); end
        expErr++;
        vectors++;
        if (n != 1024) begin
            miscompares++;
            $display("[TB] FAIL timeout_len: reqValid held %0d cycles, want 1024", n);
        end
        n = 0;
        while (io_busy === 1'b1 && n < 40) begin step(); @(negedge clock); n++; end
        vectors++;
        if (io_busy !== 1'b0 || intCycles != 4 || expWrites.size() != 0 || io_errCount !== 8'(expErr)) begin
            miscompares++;
            $display("[TB] FAIL timeout_done: busy=%b intCycles=%0d pendingWrites=%0d err=%0d, want 0/4/0/%0d",
                     io_busy, intCycles, expWrites.size(), io_errCount, expErr);
        end
    endtask

    task automatic test_timeout_race();
        int n;
        intCycles = 0;
        mem[1] = IND; mem[2] = 32'd6;
        pushResponse(32'h1234_5678);
        ringDoorbell();
        step();
        io_plInSignal = 1'b0;
        cycles(3);
        cycles(1023);
        io_respValid = 1'b1; io_respType = 32'h1234_5678;
        @(negedge clock);
        vectors++;
        if (io_reqValid !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL race_req: reqValid=%b on last wait cycle, want 1", io_reqValid);
        end
        step();
        io_respValid = 1'b0; io_respType = '0;
        n = 0;
        @(negedge clock);
        while (io_busy === 1'b1 && n < 40) begin step(); @(negedge clock); n++; end
        vectors++;
        if (io_busy !== 1'b0 || intCycles != 4 || expWrites.size() != 0 || io_errCount !== 8'(expErr)) begin
            miscompares++;
            $display("[TB] FAIL race_done: busy=%b intCycles=%0d pendingWrites=%0d err=%0d, want 0/4/0/%0d",
                     io_busy, intCycles, expWrites.size(), io_errCount, expErr);
        end
    endtask

    task automatic test_held_level();
        int n;
        intCycles = 0; reqRises = 0;
        mem[1] = IND; mem[2] = 32'd11;
        pushResponse(32'd3);
        ringDoorbell();
        cycles(4);
        io_plInSignal = 1'b0;
        step();
        io_plInSignal = 1'b1;
        io_respValid = 1'b1; io_respType = 32'd3;
        step();
        io_respValid = 1'b0; io_respType = '0;
        n = 0;
        @(negedge clock);
        while (io_busy === 1'b1 && n < 40) begin step(); @(negedge clock); n++; end
        cycles(10);
        @(negedge clock);
        vectors++;
        if (io_busy !== 1'b0 || reqRises != 1 || intCycles != 4 || expWrites.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL held_level: busy=%b reqRises=%0d intCycles=%0d pendingWrites=%0d, want 0/1/4/0",
                     io_busy, reqRises, intCycles, expWrites.size());
        end
        io_plInSignal = 1'b0;
    endtask

    task automatic test_enable_abort();
        intCycles = 0; reqRises = 0;
        mem[1] = IND; mem[2] = 32'd4;
        ringDoorbell();
        step();
        io_plInSignal = 1'b0;
        cycles(4);
        io_en = 1'b0;
        step();
        @(negedge clock);
        vectors++;
        if (io_busy !== 1'b0 || io_reqValid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL en_abort: busy=%b reqValid=%b after en=0, want 0/0", io_busy, io_reqValid);
        end
        io_en = 1'b1;
        cycles(6);
        vectors++;
        if (intCycles != 0 || reqRises != 1 || io_errCount !== 8'(expErr)) begin
            miscompares++;
            $display("[TB] FAIL en_abort_quiet: intCycles=%0d reqRises=%0d err=%0d, want 0/1/%0d",
                     intCycles, reqRises, io_errCount, expErr);
        end
    endtask

    task automatic test_err_saturation();
        mem[1] = 32'hDEAD_BEEF;
        for (int i = 0; i < 260; i++) begin
            ringDoorbell();
            step();
            io_plInSignal = 1'b0;
            cycles(3);
            if (expErr < 255) expErr++;
        end
        @(negedge clock);
        vectors++;
        if (io_errCount !== 8'(expErr) || expErr != 255) begin
            miscompares++;
            $display("[TB] FAIL err_saturate: err=%0d, want %0d (255)", io_errCount, expErr);
        end
    endtask

    task automatic test_reset_int();
        int n;
        intCycles = 0;
        mem[1] = IND; mem[2] = 32'd2;
        pushResponse(32'd8);
        ringDoorbell();
        step();
        io_plInSignal = 1'b0;
        cycles(3);
        io_respValid = 1'b1; io_respType = 32'd8;
        step();
        io_respValid = 1'b0; io_respType = '0;
        n = 0;
        @(negedge clock);
        while (io_psOutInterrupt !== 1'b1 && n < 40) begin step(); @(negedge clock); n++; end
        vectors++;
        if (io_psOutInterrupt !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL reset_int_reach: int=%b after %0d cycles, want 1", io_psOutInterrupt, n);
        end
        reset = 1'b1;
        step();
        expErr = 0;
        @(negedge clock);
        vectors++;
        if (io_psOutInterrupt !== 1'b0 || io_busy !== 1'b0 || io_errCount !== 8'd0 || expWrites.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL reset_int: int=%b busy=%b err=%0d pendingWrites=%0d, want 0/0/0/0",
                     io_psOutInterrupt, io_busy, io_errCount, expWrites.size());
        end
        reset = 1'b0;
        cycles(3);
        vectors++;
        if (intCycles != 1) begin
            miscompares++;
            $display("[TB] FAIL reset_int_len: intCycles=%0d, want 1", intCycles);
        end
    endtask

    initial begin
        for (int i = 0; i < 8192; i++) mem[i] = '0;
        io_rdData = '0;
        test_reset();
        test_normal();
        test_bad_indicator();
        test_timeout();
        test_timeout_race();
        test_held_level();
        test_enable_abort();
        test_err_saturation();
        test_reset_int();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
